// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load, shift/rotate/ASR single steps, and an
// automated N-step sequence with a busy/done handshake (IDLE -> SHIFT -> DONE).
module universal_shift_register #(
    parameter int unsigned bit_size   = 8,
    parameter int unsigned shamt_size = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [bit_size-1:0]   d,
    input  logic                  en,
    input  logic                  start,
    input  logic [2:0]            mode,
    input  logic [shamt_size-1:0] shamt,
    input  logic                  sin_l,
    input  logic                  sin_r,
    output logic [bit_size-1:0]   q,
    output logic                  sout_l,
    output logic                  sout_r,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_SHL  = 3'd1,
        OP_SHR  = 3'd2,
        OP_ROL  = 3'd3,
        OP_ROR  = 3'd4,
        OP_ASR  = 3'd5
    } op_t;

    localparam logic [shamt_size-1:0] CNT_ONE  = 1;
    localparam logic [shamt_size-1:0] CNT_ZERO = '0;

    state_t                state;
    state_t                state_next;
    op_t                   op;
    logic [shamt_size-1:0] cnt;

    // Codes 6 and 7 fall through to the default and behave as HOLD.
    function automatic logic [bit_size-1:0] step_op(
        input op_t                 sel,
        input logic [bit_size-1:0] v,
        input logic                fill_l,
        input logic                fill_r
    );
        case (sel)
            OP_SHL:  return {v[bit_size-2:0], fill_r};
            OP_SHR:  return {fill_l, v[bit_size-1:1]};
            OP_ROL:  return {v[bit_size-2:0], v[bit_size-1]};
            OP_ROR:  return {v[0], v[bit_size-1:1]};
            OP_ASR:  return {v[bit_size-1], v[bit_size-1:1]};
            default: return v;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!load && start) begin
                    state_next = (shamt != CNT_ZERO) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt == CNT_ONE) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // Datapath: the sequence latches op/cnt on start so mode/shamt are free to change mid-run.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q   <= '0;
            cnt <= '0;
            op  <= OP_HOLD;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        q <= d;
                    end else if (start) begin
                        if (shamt != CNT_ZERO) begin
                            op  <= op_t'(mode);
                            cnt <= shamt;
                        end
                    end else if (en) begin
                        q <= step_op(op_t'(mode), q, sin_l, sin_r);
                    end
                end
                SHIFT: begin
                    q   <= step_op(op, q, sin_l, sin_r);
                    cnt <= cnt - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    assign sout_l = q[bit_size-1];
    assign sout_r = q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (bit_size=8, shamt_size=4):
// a reference model pushes expected state per edge; values are popped and compared after each edge.
module tb_universal_shift_register;

    logic       clk;
    logic       rstn;
    logic       load;
    logic [7:0] d;
    logic       en;
    logic       start;
    logic [2:0] mode;
    logic [3:0] shamt;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;

    universal_shift_register #(
        .bit_size   (8),
        .shamt_size (4)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .load   (load),
        .d      (d),
        .en     (en),
        .start  (start),
        .mode   (mode),
        .shamt  (shamt),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Reference model state: 0 IDLE, 1 SHIFT, 2 DONE
    int         m_state = 0;
    logic [7:0] m_q     = 8'h00;
    int         m_cnt   = 0;
    logic [2:0] m_op    = 3'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_step(input logic [2:0] op, input logic [7:0] v,
                                            input logic fl, input logic fr);
        logic [7:0] r;
        case (op)
            3'd1:    r = (v << 1) | {7'd0, fr};
            3'd2:    r = (v >> 1) | {fl, 7'd0};
            3'd3:    r = (v << 1) | (v >> 7);
            3'd4:    r = (v >> 1) | (v << 7);
            3'd5:    r = 8'($signed(v) >>> 1);
            default: r = v;
        endcase
        return r;
    endfunction

    task automatic model_edge();
        exp_t e;
        case (m_state)
            0: begin
                if (load) begin
                    m_q = d;
                end else if (start) begin
                    if (shamt != 4'd0) begin
                        m_op    = mode;
                        m_cnt   = int'(shamt);
                        m_state = 1;
                    end else begin
                        m_state = 2;
                    end
                end else if (en) begin
                    m_q = ref_step(mode, m_q, sin_l, sin_r);
                end
            end
            1: begin
                m_q = ref_step(m_op, m_q, sin_l, sin_r);
                if (m_cnt == 1) m_state = 2;
                m_cnt--;
            end
            default: m_state = 0;
        endcase
        e.q    = m_q;
        e.busy = (m_state == 1);
        e.done = (m_state == 2);
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq("q", q, e.q);
            check_eq("busy", busy, e.busy);
            check_eq("done", done, e.done);
            check_eq("sout_l", sout_l, e.q[7]);
            check_eq("sout_r", sout_r, e.q[0]);
        end
    endtask

    task automatic step_cycle();
        model_edge();
        tick();
    endtask

    task automatic drive(input logic ld, input logic [7:0] dv, input logic e, input logic st,
                         input logic [2:0] md, input logic [3:0] sa, input logic sl, input logic sr);
        load  = ld;
        d     = dv;
        en    = e;
        start = st;
        mode  = md;
        shamt = sa;
        sin_l = sl;
        sin_r = sr;
    endtask

    task automatic idle_in();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        int busy_cnt;
        int guard;

        idle_in();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_q", q, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        rstn = 1'b1;

        // Async reset in the middle of a SHL sequence
        drive(1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
        step_cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 4'd5, 1'b0, 1'b0);
        step_cycle();
        idle_in();
        step_cycle();
        step_cycle();
        check_eq("mid_busy", busy, 1'b1);
        rstn = 1'b0;
        #2;
        check_eq("arst_q", q, 8'h00);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_done", done, 1'b0);
        m_state = 0;
        m_q     = 8'h00;
        m_cnt   = 0;
        m_op    = 3'd0;
        sb.delete();
        #2;
        rstn = 1'b1;
        step_cycle();

        // Single-step ROL
        drive(1'b1, 8'hA5, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
        step_cycle();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 4'd0, 1'b0, 1'b0);
        step_cycle();
        check_eq("rol1", q, 8'h4B);
        step_cycle();
        check_eq("rol2", q, 8'h96);
        step_cycle();
        check_eq("rol3", q, 8'h2D);
        idle_in();
        step_cycle();

        // ASR sequence of 3
        drive(1'b1, 8'h81, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
        step_cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd5, 4'd3, 1'b0, 1'b0);
        busy_cnt = 0;
        guard    = 0;
        do begin
            step_cycle();
            idle_in();
            if (busy) busy_cnt++;
            guard++;
        end while (!done && guard < 20);
        check_eq("asr_done", done, 1'b1);
        check_eq("asr_q", q, 8'hF0);
        check_eq("asr_busy_cycles", busy_cnt, 3);
        step_cycle();
        check_eq("asr_done_pulse", done, 1'b0);

        // SHL by 9 (more than width) with zero fill
        drive(1'b1, 8'h01, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
        step_cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 4'd9, 1'b0, 1'b0);
        step_cycle();
        idle_in();
        busy_cnt = 1;
        for (int i = 1; i <= 9; i++) begin
            step_cycle();
            if (busy) busy_cnt++;
            if (i == 7) begin
                check_eq("shl9_q7", q, 8'h80);
                check_eq("shl9_sout_l7", sout_l, 1'b1);
            end
        end
        check_eq("shl9_q", q, 8'h00);
        check_eq("shl9_done", done, 1'b1);
        check_eq("shl9_busy_cycles", busy_cnt, 9);
        step_cycle();

        // shamt == 0: straight to DONE
        drive(1'b1, 8'h3C, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
        step_cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 4'd0, 1'b0, 1'b0);
        step_cycle();
        idle_in();
        check_eq("sh0_busy", busy, 1'b0);
        check_eq("sh0_done", done, 1'b1);
        check_eq("sh0_q", q, 8'h3C);
        step_cycle();

        // load has priority; inputs ignored during SHIFT
        drive(1'b1, 8'h5A, 1'b1, 1'b1, 3'd1, 4'd4, 1'b0, 1'b1);
        step_cycle();
        check_eq("ldst_q", q, 8'h5A);
        check_eq("ldst_busy", busy, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 4'd2, 1'b0, 1'b0);
        step_cycle();
        drive(1'b1, 8'hFF, 1'b1, 1'b1, 3'd1, 4'd7, 1'b1, 1'b1);
        step_cycle();
        step_cycle();
        check_eq("ign_done", done, 1'b1);
        check_eq("ign_q", q, 8'h96);
        idle_in();
        step_cycle();

        // Back-to-back starts with start held high
        drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 4'd1, 1'b1, 1'b0);
        repeat (9) step_cycle();
        idle_in();
        step_cycle();
        step_cycle();

        // Random traffic, serial inputs toggling live during SHIFT
        for (int i = 0; i < 120; i++) begin
            drive(($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
            step_cycle();
        end
        idle_in();
        repeat (20) step_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
